// File: rtl/data_mem_responder_pkg.sv
// bus_params_pkg: shared LSU data bus widths and the response beat type
package bus_params_pkg;
    localparam int BUS_AW = 32;
    localparam int BUS_DW = 32;
    localparam int BUS_DBW = BUS_DW / 8;
    localparam int RSP_LATENCY_MAX = 8;

    typedef struct packed {
        logic [BUS_DW-1:0] rdata;
        logic              err;
        logic              valid;
    } rsp_t;
endpackage

// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: LSU data bus, names as seen from the LSU side
interface data_mem_responder_if;
    import bus_params_pkg::*;
    logic               data_req_o;
    logic [BUS_AW-1:0]  data_addr_o;
    logic               data_we_o;
    logic [BUS_DBW-1:0] data_be_o;
    logic [BUS_DW-1:0]  data_wdata_o;
    logic               data_gnt_i;
    logic               data_rvalid_i;
    logic [BUS_DW-1:0]  data_rdata_i;
    logic               data_err_i;

    modport master (
        output data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
        input  data_gnt_i, data_rvalid_i, data_rdata_i, data_err_i
    );
    modport slave (
        input  data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
        output data_gnt_i, data_rvalid_i, data_rdata_i, data_err_i
    );
endinterface

// File: rtl/data_mem_responder_rsp_delay_line.sv
// rsp_delay_line: fixed-depth shift register carrying response beats to the bus
module rsp_delay_line import bus_params_pkg::*; #(
    parameter int RSP_LATENCY = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  rsp_t in_i,
    output rsp_t out_o
);
    rsp_t [RSP_LATENCY-1:0] stg_q, stg_d;

    // advance every beat one stage per cycle, new beat enters stage 0
    always_comb begin
        stg_d = stg_q;
        stg_d[0] = in_i;
        for (int i = 1; i < RSP_LATENCY; i++) stg_d[i] = stg_q[i-1];
    end

    // async clear drops every in-flight beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stg_q <= '0;
        else stg_q <= stg_d;
    end

    assign out_o = stg_q[RSP_LATENCY-1];
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: byte-enabled word memory answering LSU requests after a fixed latency
module data_mem_responder import bus_params_pkg::*; #(
    parameter int MEM_DEPTH = 1024,
    parameter int RSP_LATENCY = 2,
    parameter int MAX_OUTSTANDING = 4,
    localparam int OW = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    data_mem_responder_if.slave  bus,
    input  logic                 gnt_stall_i,
    output logic [OW-1:0]        outstanding_o
);
    localparam int IW = $clog2(MEM_DEPTH);
    localparam int OFF = $clog2(BUS_DBW);

    logic [BUS_DW-1:0] mem_q [MEM_DEPTH];
    logic [IW-1:0]     idx;
    logic              oor;
    logic              acc;
    logic [OW-1:0]     cnt_q, cnt_d;
    rsp_t              rsp_in, rsp_out;

    // grant, decode and the response beat built from the pre-write array contents
    always_comb begin
        idx = bus.data_addr_o[OFF +: IW];
        oor = (bus.data_addr_o >> (OFF + IW)) != '0;
        bus.data_gnt_i = bus.data_req_o & ~gnt_stall_i & (cnt_q < OW'(MAX_OUTSTANDING));
        acc = bus.data_req_o & bus.data_gnt_i;
        rsp_in.rdata = (acc & ~bus.data_we_o & ~oor) ? mem_q[idx] : '0;
        rsp_in.err = acc & oor;
        rsp_in.valid = acc;
        cnt_d = cnt_q + OW'(acc) - OW'(rsp_out.valid);
    end

    // array is never cleared; out-of-range writes are dropped
    always_ff @(posedge clk) begin
        if (rst_n & acc & bus.data_we_o & ~oor)
            for (int b = 0; b < BUS_DBW; b++)
                if (bus.data_be_o[b]) mem_q[idx][8*b +: 8] <= bus.data_wdata_o[8*b +: 8];
    end

    // accepted-but-unanswered transaction count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end

    rsp_delay_line #(.RSP_LATENCY(RSP_LATENCY)) u_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .in_i  (rsp_in),
        .out_o (rsp_out)
    );

    // registered response beat drives the bus directly
    always_comb begin
        bus.data_rvalid_i = rsp_out.valid;
        bus.data_rdata_i = rsp_out.rdata;
        bus.data_err_i = rsp_out.err;
        outstanding_o = cnt_q;
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: two configurations checked every cycle against a transaction-level model
module tb_data_mem_responder;
    import bus_params_pkg::*;

    logic clk = 0;
    logic rst_n = 0;
    logic req = 0;
    logic we = 0;
    logic stall = 0;
    logic [31:0] addr = 0;
    logic [31:0] wdata = 0;
    logic [3:0] be = 0;
    logic [2:0] outs0;
    logic [1:0] outs1;

    always #5 clk = ~clk;

    data_mem_responder_if bus0();
    data_mem_responder_if bus1();

    assign bus0.data_req_o = req;
    assign bus0.data_addr_o = addr;
    assign bus0.data_we_o = we;
    assign bus0.data_be_o = be;
    assign bus0.data_wdata_o = wdata;
    assign bus1.data_req_o = req;
    assign bus1.data_addr_o = addr;
    assign bus1.data_we_o = we;
    assign bus1.data_be_o = be;
    assign bus1.data_wdata_o = wdata;

    data_mem_responder #(.MEM_DEPTH(1024), .RSP_LATENCY(2), .MAX_OUTSTANDING(4)) u0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0), .gnt_stall_i(stall), .outstanding_o(outs0)
    );
    data_mem_responder #(.MEM_DEPTH(1024), .RSP_LATENCY(4), .MAX_OUTSTANDING(2)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .gnt_stall_i(stall), .outstanding_o(outs1)
    );

    logic gnt_w [2];
    logic rv_w [2];
    logic err_w [2];
    logic [31:0] rd_w [2];
    logic [3:0] out_w [2];
    assign gnt_w[0] = bus0.data_gnt_i;
    assign gnt_w[1] = bus1.data_gnt_i;
    assign rv_w[0] = bus0.data_rvalid_i;
    assign rv_w[1] = bus1.data_rvalid_i;
    assign err_w[0] = bus0.data_err_i;
    assign err_w[1] = bus1.data_err_i;
    assign rd_w[0] = bus0.data_rdata_i;
    assign rd_w[1] = bus1.data_rdata_i;
    assign out_w[0] = {1'b0, outs0};
    assign out_w[1] = {2'b0, outs1};

    typedef struct {
        int due;
        logic [31:0] rd;
        logic [3:0] m;
        logic err;
    } ent_t;

    ent_t fifo [2][16];
    int hd [2];
    int tl [2];
    logic [31:0] mm [2][1024];
    logic [3:0] km [2][1024];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc [2];
    int last_rv [2];
    int rv_cnt [2];
    int peak [2];
    logic [31:0] last_rd [2];
    logic last_err [2];

    function automatic int lat(input int k);
        return k == 0 ? 2 : 4;
    endfunction

    function automatic int maxo(input int k);
        return k == 0 ? 4 : 2;
    endfunction

    task automatic chk(input string nm, input int k, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s inst%0d cyc%0d got %h exp %h", nm, k, cyc, got, exp);
        end
    endtask

    // one cycle of the reference: what the bus must show now, then what the coming edge accepts
    task automatic model_cmp();
        for (int k = 0; k < 2; k++) begin
            int n;
            logic eg;
            ent_t e;
            logic [31:0] m32;
            int w;
            logic o;
            if (!rst_n) begin
                hd[k] = tl[k];
                chk("rst_rvalid", k, 32'(rv_w[k]), 0);
                chk("rst_rdata", k, rd_w[k], 0);
                chk("rst_err", k, 32'(err_w[k]), 0);
                chk("rst_outstanding", k, 32'(out_w[k]), 0);
                chk("rst_gnt", k, 32'(gnt_w[k]), 32'(req & ~stall));
                continue;
            end
            n = tl[k] - hd[k];
            chk("outstanding", k, 32'(out_w[k]), 32'(n));
            if (int'(out_w[k]) > peak[k]) peak[k] = int'(out_w[k]);
            if (rv_w[k]) begin
                last_rv[k] = cyc;
                last_rd[k] = rd_w[k];
                last_err[k] = err_w[k];
                rv_cnt[k]++;
            end
            eg = n > 0 && fifo[k][hd[k] % 16].due == cyc;
            chk("rvalid", k, 32'(rv_w[k]), 32'(eg));
            if (eg) begin
                e = fifo[k][hd[k] % 16];
                for (int b = 0; b < 4; b++) m32[8*b +: 8] = {8{e.m[b]}};
                chk("err", k, 32'(err_w[k]), 32'(e.err));
                chk("rdata", k, rd_w[k] & m32, e.rd & m32);
                hd[k]++;
            end
            eg = req && !stall && n < maxo(k);
            chk("gnt", k, 32'(gnt_w[k]), 32'(eg));
            if (eg) begin
                w = int'(addr[11:2]);
                o = addr[31:12] != 0;
                e.due = cyc + lat(k);
                e.err = o;
                e.rd = (we || o) ? 32'h0 : mm[k][w];
                e.m = (we || o) ? 4'hF : km[k][w];
                if (we && !o)
                    for (int b = 0; b < 4; b++)
                        if (be[b]) begin
                            mm[k][w][8*b +: 8] = wdata[8*b +: 8];
                            km[k][w][b] = 1'b1;
                        end
                fifo[k][tl[k] % 16] = e;
                tl[k]++;
                last_acc[k] = cyc;
            end
        end
        cyc++;
    endtask

    task automatic tick();
        @(negedge clk);
        model_cmp();
        @(posedge clk);
        #1;
    endtask

    task automatic txn(input logic [31:0] a, input logic w, input logic [3:0] b, input logic [31:0] d);
        req = 1;
        addr = a;
        we = w;
        be = b;
        wdata = d;
        tick();
        req = 0;
        repeat (6) tick();
    endtask

    initial begin
        int base;
        for (int k = 0; k < 2; k++) begin
            hd[k] = 0;
            tl[k] = 0;
            rv_cnt[k] = 0;
            peak[k] = 0;
            last_acc[k] = 0;
            last_rv[k] = 0;
            last_rd[k] = 0;
            last_err[k] = 0;
            for (int i = 0; i < 1024; i++) begin
                km[k][i] = 0;
                mm[k][i] = 0;
            end
        end
        repeat (3) tick();
        chk("reset_outstanding", 0, 32'(out_w[0]), 0);
        chk("reset_rvalid", 1, 32'(rv_w[1]), 0);
        rst_n = 1;
        tick();

        txn(32'h40, 1, 4'hF, 32'hDEADBEEF);
        chk("wr_rdata", 0, last_rd[0], 0);
        chk("wr_err", 0, 32'(last_err[0]), 0);
        chk("wr_lat", 0, 32'(last_rv[0] - last_acc[0]), 2);
        txn(32'h40, 0, 4'hF, 0);
        chk("rd_rdata", 0, last_rd[0], 32'hDEADBEEF);
        chk("rd_err", 0, 32'(last_err[0]), 0);
        chk("rd_lat", 0, 32'(last_rv[0] - last_acc[0]), 2);
        chk("rd_lat", 1, 32'(last_rv[1] - last_acc[1]), 4);

        txn(32'h40, 1, 4'b0101, 32'h11223344);
        txn(32'h42, 0, 4'h1, 0);
        chk("be_rdata", 0, last_rd[0], 32'hDE22BE44);
        chk("be_rdata", 1, last_rd[1], 32'hDE22BE44);

        peak[0] = 0;
        peak[1] = 0;
        req = 1;
        addr = 32'h40;
        we = 0;
        repeat (12) tick();
        req = 0;
        repeat (8) tick();
        chk("peak", 0, 32'(peak[0]), 2);
        chk("peak", 1, 32'(peak[1]), 2);

        req = 1;
        stall = 1;
        repeat (3) begin
            #1 chk("stall_gnt", 0, 32'(gnt_w[0]), 0);
            tick();
        end
        stall = 0;
        #1 chk("post_stall_gnt", 0, 32'(gnt_w[0]), 1);
        chk("post_stall_gnt", 1, 32'(gnt_w[1]), 1);
        tick();
        req = 0;
        repeat (6) tick();

        txn(32'h0001_0000, 0, 4'hF, 0);
        chk("oor_err", 0, 32'(last_err[0]), 1);
        chk("oor_rdata", 0, last_rd[0], 0);
        txn(32'h0001_0040, 1, 4'hF, 32'hFFFFFFFF);
        chk("oor_wr_err", 1, 32'(last_err[1]), 1);
        txn(32'h40, 0, 4'hF, 0);
        chk("oor_unchanged", 0, last_rd[0], 32'hDE22BE44);

        req = 1;
        addr = 32'h40;
        we = 0;
        repeat (3) tick();
        req = 0;
        #1 rst_n = 0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("async_rst_rvalid", k, 32'(rv_w[k]), 0);
            chk("async_rst_outstanding", k, 32'(out_w[k]), 0);
        end
        tick();
        tick();
        rst_n = 1;
        base = rv_cnt[0] + rv_cnt[1];
        repeat (8) tick();
        chk("stale_rvalid", 0, 32'(rv_cnt[0] + rv_cnt[1] - base), 0);
        txn(32'h40, 0, 4'hF, 0);
        chk("post_rst_rdata", 0, last_rd[0], 32'hDE22BE44);
        chk("post_rst_lat", 0, 32'(last_rv[0] - last_acc[0]), 2);
        chk("post_rst_lat", 1, 32'(last_rv[1] - last_acc[1]), 4);

        repeat (1500) begin
            req = ($urandom % 10) < 6;
            we = $urandom % 2 == 0;
            be = 4'($urandom);
            wdata = $urandom;
            stall = ($urandom % 10) == 0;
            if ($urandom % 16 == 0) addr = $urandom | 32'h0000_1000;
            else addr = 32'($urandom_range(0, 15) << 2) | 32'($urandom % 4);
            tick();
        end
        req = 0;
        stall = 0;
        repeat (8) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
